// File: rtl/pos_sweep_eval.sv
// Programmable N-input product-of-sums evaluator.
// Direct registered lookup plus a handshake sweep that counts maxterms.
module pos_sweep_eval #(
  parameter int unsigned N = 4,
  parameter logic [(1<<N)-1:0] MASK_RESET = 16'hD6A8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [(1<<N)-1:0] cfg_mask,
  input  logic              in_valid,
  input  logic [N-1:0]      in_vec,
  output logic              out_valid,
  output logic              out_s,
  input  logic              start,
  input  logic              abort,
  output logic              sw_valid,
  input  logic              sw_ready,
  output logic [N-1:0]      sw_idx,
  output logic              sw_s,
  output logic              busy,
  output logic              done,
  output logic [N:0]        zero_count
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    FIN
  } state_e;

  state_e              state_q;
  logic [(1<<N)-1:0]   mask_q;
  logic [N-1:0]        idx_q;
  logic [N:0]          cnt_q;
  logic [N:0]          zc_q;
  logic                sv_q;
  logic                ss_q;
  logic                done_q;
  logic                ov_q;
  logic                os_q;

  logic                idle;
  logic                accept;
  logic                last;
  logic                zero_beat;
  logic [N-1:0]        idx_nxt;
  logic [N:0]          cnt_d;

  assign idle      = (state_q == IDLE);
  assign accept    = sv_q & sw_ready;
  assign last      = (idx_q == '1);
  assign zero_beat = ~ss_q;
  assign idx_nxt   = idx_q + N'(1);
  assign cnt_d     = cnt_q + (N+1)'(zero_beat);

  // The mask is frozen whenever the FSM is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= MASK_RESET;
    end else if (cfg_we && idle) begin
      mask_q <= cfg_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      os_q <= 1'b0;
    end else begin
      ov_q <= in_valid;
      os_q <= in_valid ? mask_q[in_vec] : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sv_q    <= 1'b0;
      idx_q   <= '0;
      ss_q    <= 1'b0;
      cnt_q   <= '0;
      zc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SWEEP;
            sv_q    <= 1'b1;
            idx_q   <= '0;
            ss_q    <= cfg_we ? cfg_mask[0] : mask_q[0];
            cnt_q   <= '0;
          end
        end
        SWEEP: begin
          if (abort) begin
            state_q <= IDLE;
            sv_q    <= 1'b0;
            idx_q   <= '0;
            ss_q    <= 1'b0;
          end else if (accept) begin
            if (last) begin
              state_q <= FIN;
              sv_q    <= 1'b0;
              idx_q   <= '0;
              ss_q    <= 1'b0;
              zc_q    <= cnt_d;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_nxt;
              ss_q  <= mask_q[idx_nxt];
              cnt_q <= cnt_d;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_valid  = ov_q;
  assign out_s      = os_q;
  assign sw_valid   = sv_q;
  assign sw_idx     = idx_q;
  assign sw_s       = ss_q;
  assign busy       = ~idle;
  assign done       = done_q;
  assign zero_count = zc_q;

endmodule
